tc_mi_rr_arbiter: RTL and testbench
===================================

// Module: tc_mi_rr_arbiter
// PURPOSE
//  Round-robin arbiter sharing one Wishbone initiator port among 4 initiators (CPU, debug, DMA, ...).
//  Output bundle feeds the i0_* port of the single-initiator-to-multi-target decoder.
//  Ownership is held per bus cycle (cyc_i), so RMW/burst sequences are never split.
//  An optional watchdog terminates hung accesses with err.
// PARAMETERS
//  WD_LIMIT   16'd1023   stb-without-ack/err cycles before watchdog err (WATCHDOG_EN only)
//  WD_W       16         watchdog counter width; WD_LIMIT must be < 2**WD_W
// PORTS
//  wb_clk_i      in   1          system clock; all logic on rising edge
//  wb_rst_i      in   1          synchronous reset, active-high
//  iN_wb_cyc_i   in   1          initiator N (N=0..3) bus cycle request
//  iN_wb_stb_i   in   1          initiator N strobe
//  iN_wb_adr_i   in   `TC_AW     initiator N address
//  iN_wb_sel_i   in   `TC_BSW    initiator N byte selects
//  iN_wb_we_i    in   1          initiator N write enable
//  iN_wb_dat_i   in   `TC_DW     initiator N write data
//  iN_wb_dat_o   out  `TC_DW     read data to initiator N (0 unless owner)
//  iN_wb_ack_o   out  1          ack to initiator N (0 unless owner)
//  iN_wb_err_o   out  1          err to initiator N (0 unless owner)
//  t_wb_cyc_o/stb_o/adr_o/sel_o/we_o/dat_o  out  1/1/`TC_AW/`TC_BSW/1/`TC_DW  shared master outputs
//  t_wb_dat_i/ack_i/err_i                   in   `TC_DW/1/1                   shared master returns
//  grant_o       out  4          one-hot current owner, 0 when idle (status/debug)
// BEHAVIOUR
//  - Reset: state IDLE, grant_o=0, last-owner pointer=3 (so i0 wins first), all t_* outputs 0,
//    all iN ack/err/dat 0, watchdog counter 0. Reset mid-cycle drops ownership immediately.
//  - FSM IDLE: if any iN_wb_cyc_i, register grant to first requester after last owner
//    (order last+1, last+2, ... mod 4); go BUSY. Grant visible next cycle (1-cycle arb latency).
//  - FSM BUSY: t_* outputs = owner's inputs (combinational from registered grant);
//    owner gets t_wb_dat_i/ack_i/err_i; non-owners see dat=0, ack=0, err=0.
//  - BUSY -> IDLE when owner cyc_i=0; last-owner pointer updated; no new grant same cycle
//    (1 dead cycle between owners). t_wb_cyc_o/stb_o gated to 0 in that cycle.
//  - Requests that drop before being granted are forgotten; no request latching.
//  - Simultaneous requests resolved only by rotation; an initiator holding cyc continuously
//    blocks others (intentional, cyc-locked); fairness only between cycles.
//  - t_wb_ack_i/err_i while IDLE: ignored, not forwarded.
//  - Owner ack and err both high: both forwarded unchanged.
// CONFIGURATION
//  `TC_ARB_WATCHDOG_EN defined:
//   - counter increments each BUSY cycle with t_wb_stb_o=1 and t_wb_ack_i=t_wb_err_i=0;
//     clears on ack/err, on stb low, on leaving BUSY.
//   - counter==WD_LIMIT: owner err_o=1 for exactly one cycle, t_wb_stb_o forced 0 that cycle,
//     counter clears; late target ack afterward is still forwarded (initiator's concern).
//  Not defined: no counter, err_o purely forwarded from t_wb_err_i; WD_* parameters unused.
// STRUCTURE
//  - Widths from the shared tc_defines include (`TC_AW, `TC_DW, `TC_BSW); add there
//    `TC_ARB_N (4) and state encodings `TC_ARB_IDLE=1'b0, `TC_ARB_BUSY=1'b1.
//  - Sub-module tc_rr_pick: combinational 4-bit request + 2-bit last pointer -> one-hot
//    grant + encoded index; reused by future multi-initiator arbiters.
//  - Top holds FSM, grant/pointer registers, bus muxes, optional watchdog.
// TESTING
//  1 Reset: hold wb_rst_i 3 cycles with all cyc=1 -> grant_o=0, t_wb_cyc_o=0; first grant after
//    release is i0 (grant_o=4'b0001) one cycle later.
//  2 Rotation: cyc on i0..i3 all held, each owner drops after 1 acked access -> grant order
//    0001,0010,0100,1000,0001 with one idle cycle between each.
//  3 Isolation: i2 owns, reads adr 0x4000_0010 returning 0xDEAD_BEEF -> only i2_wb_dat_o/ack
//    see it; i0/i1/i3 dat=0, ack=0; t_wb_adr_o=0x4000_0010.
//  4 Lock: i1 holds cyc over 3 accesses (write/read/write) while i3 requests -> i3 granted only
//    after i1 cyc falls, never mid-sequence.
//  5 Watchdog (macro on, WD_LIMIT=8): i0 strobes, target never acks -> i0_wb_err_o=1 on the
//    single cycle the counter reaches 8; t_wb_stb_o=0 that cycle; macro off -> no err ever.
//  6 Reset mid-transfer: assert wb_rst_i while i3 owns with stb high -> next cycle grant_o=0,
//    t_wb_cyc_o=0, i3 ack/err 0.

Source files
------------

// File: rtl/tc_mi_rr_arbiter_pkg.sv
// Shared tc_defines widths and the constants used by the round-robin initiator arbiter.
// The build macro TC_ARB_WATCHDOG_EN is consumed by tc_mi_rr_arbiter, not here.
`ifndef TC_DEFINES_ARB_SV
`define TC_DEFINES_ARB_SV
`ifndef TC_AW
`define TC_AW 32
`endif
`ifndef TC_DW
`define TC_DW 32
`endif
`ifndef TC_BSW
`define TC_BSW 4
`endif
`define TC_ARB_N 4
`define TC_ARB_IDLE 1'b0
`define TC_ARB_BUSY 1'b1
`endif

package tc_mi_rr_arbiter_pkg;

   localparam int ARB_AW  = `TC_AW;
   localparam int ARB_DW  = `TC_DW;
   localparam int ARB_BSW = `TC_BSW;
   localparam int ARB_N   = `TC_ARB_N;

   typedef enum logic {
      ARB_IDLE = `TC_ARB_IDLE,
      ARB_BUSY = `TC_ARB_BUSY
   } arb_state_t;

endpackage

// File: rtl/tc_mi_rr_arbiter_pick.sv
// tc_rr_pick: combinational round-robin picker, first requester after the last owner wins.
module tc_rr_pick
   import tc_mi_rr_arbiter_pkg::*;
(
   input  logic [ARB_N-1:0] i_req,
   input  logic [1:0]       i_last,
   output logic [ARB_N-1:0] o_grant,
   output logic [1:0]       o_idx,
   output logic             o_valid
);

   logic [1:0] w_cand;

   // Search last+1, last+2, ... wrapping mod 4; the 2-bit add does the wrap.
   always_comb begin
      o_grant = '0;
      o_idx   = '0;
      o_valid = 1'b0;
      w_cand  = '0;
      for (int k = 1; k <= ARB_N; k++) begin
         w_cand = i_last + 2'(k);
         if (!o_valid && i_req[w_cand]) begin
            o_valid         = 1'b1;
            o_grant[w_cand] = 1'b1;
            o_idx           = w_cand;
         end
      end
   end

endmodule

// File: rtl/tc_mi_rr_arbiter.sv
// Four-initiator round-robin Wishbone arbiter, ownership held for a whole cyc.
// Optional hung-access watchdog enabled with `define TC_ARB_WATCHDOG_EN.
module tc_mi_rr_arbiter
   import tc_mi_rr_arbiter_pkg::*;
#(
   parameter int unsigned WD_W     = 16,
   parameter logic [15:0] WD_LIMIT = 16'd1023
)
(
   input  logic              wb_clk_i,
   input  logic              wb_rst_i,
   input  logic              i0_wb_cyc_i,
   input  logic              i0_wb_stb_i,
   input  logic [ARB_AW-1:0]  i0_wb_adr_i,
   input  logic [ARB_BSW-1:0] i0_wb_sel_i,
   input  logic              i0_wb_we_i,
   input  logic [ARB_DW-1:0]  i0_wb_dat_i,
   output logic [ARB_DW-1:0]  i0_wb_dat_o,
   output logic              i0_wb_ack_o,
   output logic              i0_wb_err_o,
   input  logic              i1_wb_cyc_i,
   input  logic              i1_wb_stb_i,
   input  logic [ARB_AW-1:0]  i1_wb_adr_i,
   input  logic [ARB_BSW-1:0] i1_wb_sel_i,
   input  logic              i1_wb_we_i,
   input  logic [ARB_DW-1:0]  i1_wb_dat_i,
   output logic [ARB_DW-1:0]  i1_wb_dat_o,
   output logic              i1_wb_ack_o,
   output logic              i1_wb_err_o,
   input  logic              i2_wb_cyc_i,
   input  logic              i2_wb_stb_i,
   input  logic [ARB_AW-1:0]  i2_wb_adr_i,
   input  logic [ARB_BSW-1:0] i2_wb_sel_i,
   input  logic              i2_wb_we_i,
   input  logic [ARB_DW-1:0]  i2_wb_dat_i,
   output logic [ARB_DW-1:0]  i2_wb_dat_o,
   output logic              i2_wb_ack_o,
   output logic              i2_wb_err_o,
   input  logic              i3_wb_cyc_i,
   input  logic              i3_wb_stb_i,
   input  logic [ARB_AW-1:0]  i3_wb_adr_i,
   input  logic [ARB_BSW-1:0] i3_wb_sel_i,
   input  logic              i3_wb_we_i,
   input  logic [ARB_DW-1:0]  i3_wb_dat_i,
   output logic [ARB_DW-1:0]  i3_wb_dat_o,
   output logic              i3_wb_ack_o,
   output logic              i3_wb_err_o,
   output logic              t_wb_cyc_o,
   output logic              t_wb_stb_o,
   output logic [ARB_AW-1:0]  t_wb_adr_o,
   output logic [ARB_BSW-1:0] t_wb_sel_o,
   output logic              t_wb_we_o,
   output logic [ARB_DW-1:0]  t_wb_dat_o,
   input  logic [ARB_DW-1:0]  t_wb_dat_i,
   input  logic              t_wb_ack_i,
   input  logic              t_wb_err_i,
   output logic [ARB_N-1:0]   grant_o
);

   arb_state_t         r_state;
   arb_state_t         w_state_nxt;
   logic [ARB_N-1:0]   r_grant;
   logic [ARB_N-1:0]   w_grant_nxt;
   logic [1:0]         r_idx;
   logic [1:0]         w_idx_nxt;
   logic [1:0]         r_last;
   logic [1:0]         w_last_nxt;

   logic [ARB_N-1:0]   w_cyc;
   logic [ARB_N-1:0]   w_stb;
   logic [ARB_N-1:0]   w_we;
   logic [ARB_AW-1:0]  w_adr [ARB_N];
   logic [ARB_BSW-1:0] w_sel [ARB_N];
   logic [ARB_DW-1:0]  w_dat [ARB_N];

   logic [ARB_N-1:0]   w_pick_grant;
   logic [1:0]         w_pick_idx;
   logic               w_pick_valid;
   logic               w_busy;
   logic               w_own_cyc;
   logic               w_wd_fire;

   assign w_cyc    = {i3_wb_cyc_i, i2_wb_cyc_i, i1_wb_cyc_i, i0_wb_cyc_i};
   assign w_stb    = {i3_wb_stb_i, i2_wb_stb_i, i1_wb_stb_i, i0_wb_stb_i};
   assign w_we     = {i3_wb_we_i,  i2_wb_we_i,  i1_wb_we_i,  i0_wb_we_i};
   assign w_adr[0] = i0_wb_adr_i;
   assign w_adr[1] = i1_wb_adr_i;
   assign w_adr[2] = i2_wb_adr_i;
   assign w_adr[3] = i3_wb_adr_i;
   assign w_sel[0] = i0_wb_sel_i;
   assign w_sel[1] = i1_wb_sel_i;
   assign w_sel[2] = i2_wb_sel_i;
   assign w_sel[3] = i3_wb_sel_i;
   assign w_dat[0] = i0_wb_dat_i;
   assign w_dat[1] = i1_wb_dat_i;
   assign w_dat[2] = i2_wb_dat_i;
   assign w_dat[3] = i3_wb_dat_i;

   tc_rr_pick u_pick (
      .i_req   (w_cyc),
      .i_last  (r_last),
      .o_grant (w_pick_grant),
      .o_idx   (w_pick_idx),
      .o_valid (w_pick_valid)
   );

   assign w_busy    = (r_state == ARB_BUSY);
   assign w_own_cyc = w_cyc[r_idx];

   // Grant only from IDLE so a dead cycle always separates two owners.
   always_comb begin
      w_state_nxt = r_state;
      w_grant_nxt = r_grant;
      w_idx_nxt   = r_idx;
      w_last_nxt  = r_last;
      case (r_state)
         ARB_IDLE: begin
            if (w_pick_valid) begin
               w_state_nxt = ARB_BUSY;
               w_grant_nxt = w_pick_grant;
               w_idx_nxt   = w_pick_idx;
            end
         end
         ARB_BUSY: begin
            if (!w_own_cyc) begin
               w_state_nxt = ARB_IDLE;
               w_grant_nxt = '0;
               w_last_nxt  = r_idx;
            end
         end
         default: w_state_nxt = ARB_IDLE;
      endcase
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         r_state <= ARB_IDLE;
         r_grant <= '0;
         r_idx   <= '0;
         r_last  <= 2'd3;
      end else begin
         r_state <= w_state_nxt;
         r_grant <= w_grant_nxt;
         r_idx   <= w_idx_nxt;
         r_last  <= w_last_nxt;
      end
   end

`ifdef TC_ARB_WATCHDOG_EN
   logic [WD_W-1:0] r_wd_cnt;

   assign w_wd_fire = w_busy && (r_wd_cnt == WD_W'(WD_LIMIT));

   // Counts only consecutive stalled strobes; any progress or the fire cycle restarts it.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         r_wd_cnt <= '0;
      end else if (!w_busy || w_wd_fire || !t_wb_stb_o || t_wb_ack_i || t_wb_err_i) begin
         r_wd_cnt <= '0;
      end else begin
         r_wd_cnt <= r_wd_cnt + WD_W'(1);
      end
   end
`else
   logic w_unused_wd;

   assign w_wd_fire   = 1'b0;
   assign w_unused_wd = ^{WD_LIMIT, 32'(WD_W)};
`endif

   assign t_wb_cyc_o = w_busy & w_own_cyc;
   assign t_wb_stb_o = w_busy & w_own_cyc & w_stb[r_idx] & ~w_wd_fire;
   assign t_wb_adr_o = w_busy ? w_adr[r_idx] : '0;
   assign t_wb_sel_o = w_busy ? w_sel[r_idx] : '0;
   assign t_wb_we_o  = w_busy & w_we[r_idx];
   assign t_wb_dat_o = w_busy ? w_dat[r_idx] : '0;
   assign grant_o    = r_grant;

   // r_grant is zero outside BUSY, so it alone steers the return path.
   assign i0_wb_dat_o = r_grant[0] ? t_wb_dat_i : '0;
   assign i1_wb_dat_o = r_grant[1] ? t_wb_dat_i : '0;
   assign i2_wb_dat_o = r_grant[2] ? t_wb_dat_i : '0;
   assign i3_wb_dat_o = r_grant[3] ? t_wb_dat_i : '0;
   assign i0_wb_ack_o = r_grant[0] & t_wb_ack_i;
   assign i1_wb_ack_o = r_grant[1] & t_wb_ack_i;
   assign i2_wb_ack_o = r_grant[2] & t_wb_ack_i;
   assign i3_wb_ack_o = r_grant[3] & t_wb_ack_i;
   assign i0_wb_err_o = r_grant[0] & (t_wb_err_i | w_wd_fire);
   assign i1_wb_err_o = r_grant[1] & (t_wb_err_i | w_wd_fire);
   assign i2_wb_err_o = r_grant[2] & (t_wb_err_i | w_wd_fire);
   assign i3_wb_err_o = r_grant[3] & (t_wb_err_i | w_wd_fire);

endmodule

// File: tb/tb_tc_mi_rr_arbiter.sv
// Self-checking bench for tc_mi_rr_arbiter: directed scenarios plus a randomized
// run against an owner/last-pointer reference model.
module tb_tc_mi_rr_arbiter;
   import tc_mi_rr_arbiter_pkg::*;

`ifdef TC_ARB_WATCHDOG_EN
   localparam bit WD_ON = 1'b1;
`else
   localparam bit WD_ON = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [3:0] cyc = '0;
   logic [3:0] stb = '0;
   logic [3:0] we  = '0;
   logic [3:0][ARB_AW-1:0]  adr  = '0;
   logic [3:0][ARB_BSW-1:0] sel  = '0;
   logic [3:0][ARB_DW-1:0]  wdat = '0;
   logic [ARB_DW-1:0] t_dat_i = '0;
   logic t_ack = 1'b0;
   logic t_err = 1'b0;

   wire [ARB_DW-1:0] rdat0, rdat1, rdat2, rdat3;
   wire ack0, ack1, ack2, ack3, err0, err1, err2, err3;
   wire t_cyc, t_stb, t_we;
   wire [ARB_AW-1:0]  t_adr;
   wire [ARB_BSW-1:0] t_sel;
   wire [ARB_DW-1:0]  t_dat_o;
   wire [3:0] grant;
   wire [3:0][ARB_DW-1:0] rdat = {rdat3, rdat2, rdat1, rdat0};
   wire [3:0] ack_o = {ack3, ack2, ack1, ack0};
   wire [3:0] err_o = {err3, err2, err1, err0};

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   tc_mi_rr_arbiter #(.WD_W(16), .WD_LIMIT(16'd8)) dut (
      .wb_clk_i(clk), .wb_rst_i(rst),
      .i0_wb_cyc_i(cyc[0]), .i0_wb_stb_i(stb[0]), .i0_wb_adr_i(adr[0]), .i0_wb_sel_i(sel[0]),
      .i0_wb_we_i(we[0]), .i0_wb_dat_i(wdat[0]), .i0_wb_dat_o(rdat0), .i0_wb_ack_o(ack0), .i0_wb_err_o(err0),
      .i1_wb_cyc_i(cyc[1]), .i1_wb_stb_i(stb[1]), .i1_wb_adr_i(adr[1]), .i1_wb_sel_i(sel[1]),
      .i1_wb_we_i(we[1]), .i1_wb_dat_i(wdat[1]), .i1_wb_dat_o(rdat1), .i1_wb_ack_o(ack1), .i1_wb_err_o(err1),
      .i2_wb_cyc_i(cyc[2]), .i2_wb_stb_i(stb[2]), .i2_wb_adr_i(adr[2]), .i2_wb_sel_i(sel[2]),
      .i2_wb_we_i(we[2]), .i2_wb_dat_i(wdat[2]), .i2_wb_dat_o(rdat2), .i2_wb_ack_o(ack2), .i2_wb_err_o(err2),
      .i3_wb_cyc_i(cyc[3]), .i3_wb_stb_i(stb[3]), .i3_wb_adr_i(adr[3]), .i3_wb_sel_i(sel[3]),
      .i3_wb_we_i(we[3]), .i3_wb_dat_i(wdat[3]), .i3_wb_dat_o(rdat3), .i3_wb_ack_o(ack3), .i3_wb_err_o(err3),
      .t_wb_cyc_o(t_cyc), .t_wb_stb_o(t_stb), .t_wb_adr_o(t_adr), .t_wb_sel_o(t_sel),
      .t_wb_we_o(t_we), .t_wb_dat_o(t_dat_o), .t_wb_dat_i(t_dat_i), .t_wb_ack_i(t_ack),
      .t_wb_err_i(t_err), .grant_o(grant)
   );

   // Inputs change 1 time unit after the rising edge; outputs are sampled 2 units later.
   task automatic nextc();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   task automatic do_reset();
      rst = 1'b1; cyc = '0; stb = '0; t_ack = 1'b0; t_err = 1'b0;
      nextc();
      nextc();
      rst = 1'b0;
   endtask

   task automatic go_idle();
      cyc = '0; stb = '0; t_ack = 1'b0; t_err = 1'b0;
      nextc();
      nextc();
   endtask

   task automatic test_reset();
      rst = 1'b1; cyc = 4'hF; stb = '0;
      for (int i = 0; i < 3; i++) begin
         nextc();
         settle();
         checks++;
         if (grant !== 4'b0000) begin
            errors++; $display("[TB] FAIL reset_grant: got %b expected 0000", grant);
         end
         checks++;
         if (t_cyc !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_tcyc: got %b expected 0", t_cyc);
         end
      end
      rst = 1'b0;
      settle();
      checks++;
      if (grant !== 4'b0000) begin
         errors++; $display("[TB] FAIL release_grant: got %b expected 0000", grant);
      end
      nextc();
      settle();
      checks++;
      if (grant !== 4'b0001) begin
         errors++; $display("[TB] FAIL first_grant: got %b expected 0001", grant);
      end
      go_idle();
   endtask

   task automatic test_rotation();
      int order [5] = '{0, 1, 2, 3, 0};
      logic [3:0] exp_g;
      do_reset();
      cyc = 4'hF; stb = 4'hF;
      for (int k = 0; k < 5; k++) begin
         exp_g = 4'(1 << order[k]);
         nextc();
         settle();
         checks++;
         if (grant !== exp_g) begin
            errors++; $display("[TB] FAIL rotation_grant%0d: got %b expected %b", k, grant, exp_g);
         end
         t_ack = 1'b1;
         settle();
         checks++;
         if (ack_o !== exp_g) begin
            errors++; $display("[TB] FAIL rotation_ack%0d: got %b expected %b", k, ack_o, exp_g);
         end
         nextc();
         t_ack = 1'b0; cyc[order[k]] = 1'b0; stb[order[k]] = 1'b0;
         settle();
         checks++;
         if (t_cyc !== 1'b0 || t_stb !== 1'b0) begin
            errors++; $display("[TB] FAIL rotation_drop%0d: got cyc=%b stb=%b expected 0 0", k, t_cyc, t_stb);
         end
         nextc();
         cyc = 4'hF; stb = 4'hF;
         settle();
         checks++;
         if (grant !== 4'b0000) begin
            errors++; $display("[TB] FAIL rotation_dead%0d: got %b expected 0000", k, grant);
         end
      end
      go_idle();
   endtask

   task automatic test_isolation();
      do_reset();
      for (int n = 0; n < 4; n++) begin
         adr[n] = 32'h1000_0000 + 32'(n); wdat[n] = 32'h5555_0000 + 32'(n); we[n] = 1'b1;
      end
      adr[2] = 32'h4000_0010; we[2] = 1'b0; sel[2] = 4'hF;
      cyc[2] = 1'b1; stb[2] = 1'b1;
      nextc();
      t_dat_i = 32'hDEAD_BEEF; t_ack = 1'b1;
      settle();
      checks++;
      if (grant !== 4'b0100) begin
         errors++; $display("[TB] FAIL iso_grant: got %b expected 0100", grant);
      end
      checks++;
      if (t_adr !== 32'h4000_0010 || t_we !== 1'b0) begin
         errors++; $display("[TB] FAIL iso_adr: got %h/%b expected 40000010/0", t_adr, t_we);
      end
      checks++;
      if (rdat !== {32'h0, 32'hDEAD_BEEF, 32'h0, 32'h0}) begin
         errors++; $display("[TB] FAIL iso_dat: got %h expected only i2=deadbeef", rdat);
      end
      checks++;
      if (ack_o !== 4'b0100) begin
         errors++; $display("[TB] FAIL iso_ack: got %b expected 0100", ack_o);
      end
      t_dat_i = '0;
      go_idle();
   endtask

   task automatic test_lock();
      do_reset();
      cyc[1] = 1'b1; cyc[3] = 1'b1; stb[3] = 1'b1;
      nextc();
      for (int a = 0; a < 3; a++) begin
         we[1] = (a != 1); stb[1] = 1'b1; t_ack = 1'b1;
         settle();
         checks++;
         if (grant !== 4'b0010 || t_we !== we[1]) begin
            errors++; $display("[TB] FAIL lock_access%0d: got grant=%b we=%b expected 0010 %b", a, grant, t_we, we[1]);
         end
         checks++;
         if (ack_o !== 4'b0010) begin
            errors++; $display("[TB] FAIL lock_ack%0d: got %b expected 0010", a, ack_o);
         end
         nextc();
      end
      cyc[1] = 1'b0; stb[1] = 1'b0; t_ack = 1'b0;
      settle();
      checks++;
      if (grant !== 4'b0010 || t_cyc !== 1'b0) begin
         errors++; $display("[TB] FAIL lock_release: got grant=%b cyc=%b expected 0010 0", grant, t_cyc);
      end
      nextc();
      settle();
      checks++;
      if (grant !== 4'b0000) begin
         errors++; $display("[TB] FAIL lock_dead: got %b expected 0000", grant);
      end
      nextc();
      settle();
      checks++;
      if (grant !== 4'b1000) begin
         errors++; $display("[TB] FAIL lock_next: got %b expected 1000", grant);
      end
      go_idle();
   endtask

   task automatic test_watchdog();
      logic exp_fire;
      do_reset();
      cyc[0] = 1'b1; stb[0] = 1'b1;
      nextc();
      for (int c = 0; c < 10; c++) begin
         exp_fire = WD_ON && (c == 8);
         settle();
         checks++;
         if (err_o !== {3'b000, exp_fire}) begin
            errors++; $display("[TB] FAIL wd_err%0d: got %b expected %b", c, err_o, {3'b000, exp_fire});
         end
         checks++;
         if (t_stb !== !exp_fire) begin
            errors++; $display("[TB] FAIL wd_stb%0d: got %b expected %b", c, t_stb, !exp_fire);
         end
         nextc();
      end
      t_ack = 1'b1;
      settle();
      checks++;
      if (ack_o !== 4'b0001) begin
         errors++; $display("[TB] FAIL wd_late_ack: got %b expected 0001", ack_o);
      end
      go_idle();
   endtask

   task automatic test_reset_mid();
      do_reset();
      cyc[3] = 1'b1; stb[3] = 1'b1;
      nextc();
      settle();
      checks++;
      if (grant !== 4'b1000 || t_stb !== 1'b1) begin
         errors++; $display("[TB] FAIL mid_owner: got grant=%b stb=%b expected 1000 1", grant, t_stb);
      end
      rst = 1'b1; t_ack = 1'b1; t_err = 1'b1;
      nextc();
      settle();
      checks++;
      if (grant !== 4'b0000 || t_cyc !== 1'b0) begin
         errors++; $display("[TB] FAIL mid_drop: got grant=%b cyc=%b expected 0000 0", grant, t_cyc);
      end
      checks++;
      if (ack_o[3] !== 1'b0 || err_o[3] !== 1'b0) begin
         errors++; $display("[TB] FAIL mid_ackerr: got ack=%b err=%b expected 0 0", ack_o[3], err_o[3]);
      end
      rst = 1'b0;
      go_idle();
   endtask

   // Reference model: owner is -1 when idle; rotation starts after the last owner.
   task automatic test_random();
      int owner = -1;
      int last  = 3;
      int stall = 0;
      logic [3:0] e_grant, e_ack, e_err;
      logic e_cyc, e_stb;
      logic [3:0][ARB_DW-1:0] e_rdat;
      logic [ARB_AW+ARB_BSW+ARB_DW:0] e_bus, a_bus;
      do_reset();
      for (int c = 0; c < 300; c++) begin
         nextc();
         if (owner < 0) begin
            for (int k = 1; k <= 4; k++) begin
               if (owner < 0 && cyc[(last + k) % 4]) owner = (last + k) % 4;
            end
         end else if (!cyc[owner]) begin
            last  = owner;
            owner = -1;
         end
         for (int n = 0; n < 4; n++) begin
            if (cyc[n]) begin
               if ($urandom_range(3) == 0) cyc[n] = 1'b0;
            end else if ($urandom_range(2) == 0) begin
               cyc[n] = 1'b1;
            end
            stb[n]  = 1'($urandom_range(1));
            we[n]   = 1'($urandom_range(1));
            adr[n]  = $urandom;
            sel[n]  = 4'($urandom);
            wdat[n] = $urandom;
         end
         t_dat_i = $urandom;
         t_err   = ($urandom_range(7) == 0);
         t_ack   = 1'($urandom_range(1));
         e_cyc   = 1'b0;
         e_stb   = 1'b0;
         e_grant = '0;
         e_bus   = '0;
         e_rdat  = '0;
         if (owner >= 0) begin
            e_cyc   = cyc[owner];
            e_stb   = cyc[owner] && stb[owner];
            e_grant = 4'(1 << owner);
            e_bus   = {adr[owner], sel[owner], we[owner], wdat[owner]};
            e_rdat[owner] = t_dat_i;
         end
         if (e_stb && stall >= 3) t_ack = 1'b1;
         stall = (e_stb && !t_ack && !t_err) ? stall + 1 : 0;
         e_ack = t_ack ? e_grant : 4'b0000;
         e_err = t_err ? e_grant : 4'b0000;
         settle();
         a_bus = {t_adr, t_sel, t_we, t_dat_o};
         checks++;
         if (grant !== e_grant) begin
            errors++; $display("[TB] FAIL rnd_grant c%0d: got %b expected %b", c, grant, e_grant);
         end
         checks++;
         if (t_cyc !== e_cyc || t_stb !== e_stb) begin
            errors++; $display("[TB] FAIL rnd_cycstb c%0d: got %b%b expected %b%b", c, t_cyc, t_stb, e_cyc, e_stb);
         end
         checks++;
         if (a_bus !== e_bus) begin
            errors++; $display("[TB] FAIL rnd_bus c%0d: got %h expected %h", c, a_bus, e_bus);
         end
         checks++;
         if (ack_o !== e_ack || err_o !== e_err) begin
            errors++; $display("[TB] FAIL rnd_ackerr c%0d: got %b/%b expected %b/%b", c, ack_o, err_o, e_ack, e_err);
         end
         checks++;
         if (rdat !== e_rdat) begin
            errors++; $display("[TB] FAIL rnd_rdat c%0d: got %h expected %h", c, rdat, e_rdat);
         end
      end
      go_idle();
   endtask

   initial begin
      test_reset();
      test_rotation();
      test_isolation();
      test_lock();
      test_watchdog();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
